// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into the instruction memory from address 0 and
// holds the CPU in reset until a clean load. Define PROG_LOADER_CHECKSUM_EN for a trailing checksum byte.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              mem_read,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_,
    output logic [ADDR_W:0]   load_count
);

    // Handshake: a byte transfers on any posedge where in_valid && in_ready; in_ready is
    // registered and never depends on in_valid, and in_data is captured on that edge.
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t          state, state_d;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] cnt_inc;
    logic            bad_q;
    logic            start_ok, start_bad, pay_acc, all_in, ready_d, chk_fail;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              chk_got_q, chk_bad_q, chk_acc;

    // Once len payload bytes are in, the next accepted byte is the checksum.
    assign chk_acc  = (state == LOAD) && in_valid && in_ready && (load_count == len_q);
    assign all_in   = (load_count == len_q) && chk_got_q;
    assign ready_d  = (cnt_inc < len_q) || !(chk_got_q || chk_acc);
    assign chk_fail = chk_bad_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sum_q     <= '0;
            chk_got_q <= 1'b0;
            chk_bad_q <= 1'b0;
        end else if (start_ok) begin
            sum_q     <= '0;
            chk_got_q <= 1'b0;
            chk_bad_q <= 1'b0;
        end else begin
            if (pay_acc) sum_q <= sum_q + in_data;
            if (chk_acc) begin
                chk_got_q <= 1'b1;
                chk_bad_q <= (in_data != sum_q);
            end
        end
    end
`else
    assign all_in   = (load_count == len_q);
    assign ready_d  = (cnt_inc < len_q);
    assign chk_fail = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        pay_acc   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= DEPTH_C) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                pay_acc = in_valid && in_ready && (load_count < len_q);
                // Leave one cycle after the final accept so its write is issued before DRAIN.
                if (all_in) state_d = DRAIN;
            end
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_inc = load_count + {{ADDR_W{1'b0}}, pay_acc};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            in_ready   <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_write  <= 1'b0;
            error      <= 1'b0;
            cpu_rst_   <= 1'b0;
            load_count <= '0;
            len_q      <= '0;
            bad_q      <= 1'b0;
        end else begin
            mem_write <= pay_acc;
            bad_q     <= start_bad;
            if (start_ok) begin
                len_q      <= len;
                error      <= 1'b0;
                load_count <= '0;
                cpu_rst_   <= 1'b0;
                in_ready   <= 1'b1;
            end else begin
                in_ready <= (state == LOAD) && ready_d;
                if (start_bad) error <= 1'b1;
                if (pay_acc) begin
                    mem_addr   <= load_count[ADDR_W-1:0];
                    mem_data   <= in_data;
                    load_count <= cnt_inc;
                end
                if (state == DRAIN) begin
                    cpu_rst_ <= !chk_fail;
                    if (chk_fail) error <= 1'b1;
                end
            end
        end
    end

    // The loader only ever writes; reads belong to the CPU once released.
    assign mem_read = 1'b0;
    assign busy     = (state == LOAD) || (state == DRAIN);
    assign done     = (state == FINISH) || bad_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads, hand-written corner sequences and
// randomized loads checked against a transaction-level model of memory writes and flags.
module tb_prog_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, mem_write, mem_read, busy, done, error, cpu_rst_;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W:0]   load_count;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_), .start(start), .len(len), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_write(mem_write), .mem_read(mem_read), .busy(busy), .done(done),
        .error(error), .cpu_rst_(cpu_rst_), .load_count(load_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_n = 0;
    int done_cyc = 0;
    logic done_cpu = 1'b0;
    int rw_clash = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                wr_cyc_q[$];
    int                acc_cyc_q[$];
    logic [DATA_W-1:0] pay_q[$];
    logic [DATA_W-1:0] strm_q[$];
    logic m_cpu = 1'b0;
    int   m_cnt = 0;

    typedef struct {
        int   len;
        int   base;
        int   step;
        int   gap;
        int   vpat;
        int   busy_at;
        logic exp_err;
        logic exp_cpu;
    } vec_t;
    vec_t tbl[7];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mem_write) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
            done_cpu = cpu_rst_;
        end
        if (mem_write && mem_read) rw_clash = rw_clash + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({in_ready, mem_addr, mem_data, mem_write, mem_read, busy, done, error,
                     cpu_rst_, load_count});
    endfunction

    function automatic logic [7:0] sum8();
        int s = 0;
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send_stream(input int gap, input int vpat, input int busy_at);
        int   idx = 0;
        int   k = 0;
        logic took;
        while (idx < strm_q.size() && k < 300) begin
            if (vpat != 0 && k < 32) in_valid = vpat[k];
            else                     in_valid = ($urandom_range(99) >= gap);
            in_data = in_valid ? strm_q[idx] : 8'($urandom);
            if (k == busy_at) begin
                start = 1'b1;
                len   = 3;
            end else begin
                start = 1'b0;
                len   = '0;
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc_cyc_q.push_back(cyc);
            @(posedge clk); #1;
            if (took) idx++;
            k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        len      = '0;
        chk("stream_accepted", idx, strm_q.size());
    endtask

    // Runs one load of pay_q (caller fills exactly l bytes when l is legal) and checks the
    // resulting write trace and flags against the expected outcome.
    task automatic run_load(input string nm, input int l, input int gap, input int vpat,
                            input int busy_at, input logic [7:0] chk_byte,
                            input logic exp_err, input logic exp_cpu);
        bit legal;
        int exp_wr;
        int k;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
        done_n = 0;
        legal  = (l >= 1 && l <= DEPTH);
        exp_wr = legal ? l : 0;
        do_start(l);
        if (legal) begin
            strm_q = pay_q;
            if (CHK_EN) strm_q.push_back(chk_byte);
            send_stream(gap, vpat, busy_at);
            chk({nm, "_ready_low_after_last"}, int'(in_ready), 0);
        end
        k = 0;
        while (done_n == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (legal) m_cnt = l;
        m_cpu = exp_cpu;
        chk({nm, "_done_pulses"}, done_n, 1);
        chk({nm, "_write_count"}, wr_addr_q.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr[%0d]", nm, i), int'(wr_addr_q[i]), i);
            chk($sformatf("%s_data[%0d]", nm, i), int'(wr_data_q[i]), int'(pay_q[i]));
            if (i < acc_cyc_q.size())
                chk($sformatf("%s_wr_cycle[%0d]", nm, i), wr_cyc_q[i], acc_cyc_q[i] + 1);
        end
        chk({nm, "_error"}, int'(error), int'(exp_err));
        chk({nm, "_cpu_rst_"}, int'(cpu_rst_), int'(exp_cpu));
        chk({nm, "_load_count"}, int'(load_count), m_cnt);
        chk({nm, "_busy"}, int'(busy), 0);
        if (legal && acc_cyc_q.size() > 0) begin
            chk({nm, "_cpu_rst_at_done"}, int'(done_cpu), int'(exp_cpu));
            chk({nm, "_done_latency"}, done_cyc - acc_cyc_q[$], 3);
        end
    endtask

    initial begin
        logic [7:0] cb;
        int         l;
        bit         ok;

        tbl[0] = '{3,  8'hA0, 8'h11, 0,  0, -1, 1'b0, 1'b1};  // basic back-to-back
        tbl[1] = '{2,  8'h3C, 8'h05, 0,  9, -1, 1'b0, 1'b1};  // valid pattern 1,0,0,1
        tbl[2] = '{32, 0,     1,     0,  0, -1, 1'b0, 1'b1};  // full memory
        tbl[3] = '{0,  0,     0,     0,  0, -1, 1'b1, 1'b1};  // illegal, cpu_rst_ kept
        tbl[4] = '{33, 0,     0,     0,  0, -1, 1'b1, 1'b1};  // illegal, too long
        tbl[5] = '{1,  8'hFF, 0,     0,  0, -1, 1'b0, 1'b1};
        tbl[6] = '{5,  8'h10, 8'h23, 30, 0, 2,  1'b0, 1'b1};  // start while busy

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        rst_ = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", all_outs(), 0);

        foreach (tbl[t]) begin
            pay_q.delete();
            if (tbl[t].len >= 1 && tbl[t].len <= DEPTH)
                for (int i = 0; i < tbl[t].len; i++)
                    pay_q.push_back(8'(tbl[t].base + i * tbl[t].step));
            run_load($sformatf("tbl%0d", t), tbl[t].len, tbl[t].gap, tbl[t].vpat,
                     tbl[t].busy_at, sum8(), tbl[t].exp_err, tbl[t].exp_cpu);
        end

        // Asynchronous reset in the middle of a load.
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start(4);
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(posedge clk); #1;
        in_data  = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midload_write_pending", int'(mem_write), 1);
        #2 rst_ = 1'b0;
        #1;
        chk("midload_reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk); #1;
        m_cpu = 1'b0;
        m_cnt = 0;
        pay_q = '{8'h5A};
        run_load("after_reset", 1, 0, 0, -1, sum8(), 1'b0, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
        pay_q = '{8'h80, 8'h90};
        run_load("chk_good", 2, 0, 0, -1, 8'h10, 1'b0, 1'b1);
        run_load("chk_bad", 2, 0, 0, -1, 8'h11, 1'b1, 1'b0);
        run_load("chk_good_again", 2, 0, 0, -1, 8'h10, 1'b0, 1'b1);
`endif

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(9) < 8) l = $urandom_range(DEPTH, 1);
            else                       l = ($urandom_range(1) == 0) ? 0 : $urandom_range(63, DEPTH + 1);
            pay_q.delete();
            if (l >= 1 && l <= DEPTH)
                for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
            cb = sum8();
            if ($urandom_range(3) == 0) cb = cb + 8'($urandom_range(255, 1));
            if (l >= 1 && l <= DEPTH) begin
                ok = !CHK_EN || (cb == sum8());
                run_load($sformatf("rnd%0d", r), l, $urandom_range(60), 0, -1, cb, !ok, ok);
            end else begin
                run_load($sformatf("rnd%0d", r), l, 0, 0, -1, cb, 1'b1, m_cpu);
            end
        end

        chk("read_write_exclusive", rw_clash, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
